axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI3-style slave endpoint that terminates one axi_intf: accepts AW/W bursts into an internal
//  dual-port word array and returns B, serves AR bursts with R beats. Sits directly downstream of
//  the interconnect master port; serves as SoC-env memory responder and low-power handshake partner.
// PARAMETERS
//  ADDR_WIDTH     32    byte address width
//  DATA_WIDTH     64    data bus width, power of 2 >= 8; STRB = DATA_WIDTH/8
//  ID_WIDTH       4     awid/wid/bid/arid/rid width
//  LEN_WIDTH      4     burst length field width (beats = len+1)
//  SIDEBAND_WIDTH 4     sideband width; echoed, never interpreted
//  MEM_DEPTH      1024  array depth in DATA_WIDTH words, power of 2
// PORTS
//  clock     in   1      single clock, all logic rising-edge
//  reset     in   1      synchronous, active-high
//  aw*       in   -      awvalid/addr/len/size/burst/lock/cache/prot/id/sideband; awready out 1
//  w*        in   -      wvalid/wdata/wstrb/wid/wsideband/wlast; wready out 1
//  b*        out  -      bvalid/bresp(2)/bid/bsideband; bready in 1
//  ar*       in   -      arvalid/addr/len/size/burst/lock/cache/prot/id/sideband; arready out 1
//  r*        out  -      rvalid/rdata/rstrb/rid/rsideband/rlast/rresp(2); rready in 1
//  csysreq   in   1      low-power request (1 = run)
//  csysack   out  1      low-power acknowledge
//  cactive   out  1      1 while any transaction is in flight
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, bresp/rresp 0, rstrb 0, cactive 0, csysack 1; FSMs -> IDLE.
//  Write FSM WR_IDLE->WR_DATA->WR_RESP->WR_IDLE. WR_IDLE: awready=1 (if csysack). AW hs cycle N:
//   latch id/len/size/burst/sideband/addr; wready=1 from N+1. Each W hs writes word[idx] under wstrb;
//   beat counter 0..len; beat len accepted -> bvalid at next cycle, bid=awid, bsideband=awsideband.
//   wlast!=(cnt==len) on any beat -> bresp SLVERR, burst still ends at cnt==len. wid ignored.
//  Read FSM RD_IDLE->RD_DATA->RD_IDLE. AR hs cycle N -> rvalid at N+1 (registered array read).
//   rdata/rid/rlast/rresp held stable while rvalid & !rready; next beat fetched on hs, no bubble.
//   rlast on beat len; rstrb all-ones; rid=arid, rsideband=arsideband.
//  Address gen: idx = addr >> log2(STRB); INCR adds 1<<size bytes per beat (mod 2^ADDR_WIDTH);
//   FIXED holds addr; WRAP -> SLVERR on every beat/B, no array write, rdata 0.
//  awsize/arsize > log2(STRB) -> SLVERR, same as WRAP.
//  Simultaneous read+write same word same cycle: read returns old data. Read/write FSMs independent.
//  B after final W only; no new AW until bvalid&bready (one outstanding write, one outstanding read).
//  Low power: csysreq 1->0 accepted only when both FSMs IDLE and no AW/AR hs that cycle; csysack=0
//   next cycle, awready=arready=0 while csysack=0. csysreq 0->1 -> csysack=1 next cycle.
//  cactive = (wr_state!=WR_IDLE)|(rd_state!=RD_IDLE), registered.
//  Reset mid-burst: bursts abandoned, no B/R emitted, array contents retained.
// CONFIGURATION
//  AXI_SLV_DECERR_EN defined: byte address >= MEM_DEPTH*STRB -> DECERR (2'b11) on B/R, writes
//   dropped, rdata 0; checked per beat. Undefined: idx taken modulo MEM_DEPTH, resp OKAY.
// STRUCTURE
//  axi_slv_pkg: resp_e (OKAY/EXOKAY/SLVERR/DECERR), burst_e (FIXED/INCR/WRAP), wr_state_e,
//   rd_state_e, STRB/log2 helper function.
//  Sub-module axi_slv_addr_gen: next-address + index + error calc, instanced once per FSM.
// TESTING
//  1) AW addr 0x100 len 3 INCR size 3, 4 W beats strb 0xFF -> B OKAY 1 cycle after 4th W hs;
//     AR same -> 4 R beats match, rlast on beat 4 only.
//  2) W strb 0x0F data 0xAAAA_BBBB_CCCC_DDDD over word of 0 -> read returns 0x0000_0000_CCCC_DDDD.
//  3) rready held 0 for 5 cycles mid-burst -> rdata/rlast stable, no beat lost or duplicated.
//  4) len 3 with wlast on beat 2 -> bresp SLVERR after 4th beat; AW burst WRAP -> SLVERR, mem unchanged.
//  5) addr MEM_DEPTH*8: DECERR_EN -> bresp/rresp 2'b11; else wraps to word 0, OKAY.
//  6) csysreq drop during burst -> csysack stays 1 until B done; then 0, awready/arready 0; rise -> resume.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI SRAM slave and its address generator.
// Build option AXI_SLV_DECERR_EN (consumed by axi_slv_addr_gen) enables out-of-range DECERR.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  function automatic int log2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int strb_f(input int data_width);
    return data_width / 8;
  endfunction

  // Encodings are ordered by severity, so the worst response is the numerically largest.
  function automatic resp_e resp_max(input resp_e a, input resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Per-beat address step, word index and response classification for one burst.
// With AXI_SLV_DECERR_EN defined, addresses beyond the array return DECERR instead of aliasing.
module axi_slv_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 1024,
  localparam int IDX_W     = log2_f(MEM_DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [IDX_W-1:0]      idx,
  output resp_e                 resp
);

  localparam int LOG2_STRB = log2_f(strb_f(DATA_WIDTH));

  logic fmt_err;

  // WRAP, the reserved burst code and beats wider than the bus are all unsupported.
  assign fmt_err   = (size > 3'(LOG2_STRB)) ||
                     !((burst == BURST_INCR) || (burst == BURST_FIXED));
  assign idx       = addr[LOG2_STRB +: IDX_W];
  assign next_addr = (burst == BURST_INCR) ? addr + (ADDR_WIDTH'(1) << size) : addr;

`ifdef AXI_SLV_DECERR_EN
  logic range_err;
  assign range_err = |addr[ADDR_WIDTH-1:LOG2_STRB+IDX_W];

  always_comb begin
    resp = RESP_OKAY;
    if (fmt_err)        resp = RESP_SLVERR;
    else if (range_err) resp = RESP_DECERR;
  end
`else
  always_comb begin
    resp = RESP_OKAY;
    if (fmt_err) resp = RESP_SLVERR;
  end
`endif

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM slave: one outstanding write and one outstanding read over a byte-lane array.
// Define AXI_SLV_DECERR_EN to answer out-of-range addresses with DECERR instead of aliasing.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int LEN_WIDTH      = 4,
  parameter int SIDEBAND_WIDTH = 4,
  parameter int MEM_DEPTH      = 1024,
  localparam int STRB_W        = DATA_WIDTH / 8,
  localparam int IDX_W         = log2_f(MEM_DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      awvalid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [LEN_WIDTH-1:0]      awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic [1:0]                awlock,
  input  logic [3:0]                awcache,
  input  logic [2:0]                awprot,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [SIDEBAND_WIDTH-1:0] awsideband,
  output logic                      awready,
  input  logic                      wvalid,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [STRB_W-1:0]         wstrb,
  input  logic [ID_WIDTH-1:0]       wid,
  input  logic [SIDEBAND_WIDTH-1:0] wsideband,
  input  logic                      wlast,
  output logic                      wready,
  output logic                      bvalid,
  output logic [1:0]                bresp,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [SIDEBAND_WIDTH-1:0] bsideband,
  input  logic                      bready,
  input  logic                      arvalid,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic [LEN_WIDTH-1:0]      arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic [1:0]                arlock,
  input  logic [3:0]                arcache,
  input  logic [2:0]                arprot,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [SIDEBAND_WIDTH-1:0] arsideband,
  output logic                      arready,
  output logic                      rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [STRB_W-1:0]         rstrb,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [SIDEBAND_WIDTH-1:0] rsideband,
  output logic                      rlast,
  output logic [1:0]                rresp,
  input  logic                      rready,
  input  logic                      csysreq,
  output logic                      csysack,
  output logic                      cactive
);

  wr_state_e wr_state_reg, wr_state_next;
  rd_state_e rd_state_reg, rd_state_next;
  logic csysack_reg, cactive_reg;

  logic [ADDR_WIDTH-1:0]     wr_addr_reg, rd_addr_reg;
  logic [LEN_WIDTH-1:0]      wr_len_reg, wr_cnt_reg, rd_len_reg, rd_cnt_reg;
  logic [2:0]                wr_size_reg, rd_size_reg;
  logic [1:0]                wr_burst_reg, rd_burst_reg;
  logic [ID_WIDTH-1:0]       wr_id_reg, rd_id_reg;
  logic [SIDEBAND_WIDTH-1:0] wr_side_reg, rd_side_reg;
  resp_e                     wr_resp_reg, rd_resp_reg, wr_resp_next;
  logic                      rd_last_reg;
  logic [STRB_W-1:0]         rd_strb_reg;

  logic aw_hs, w_hs, ar_hs, r_hs, wr_last_beat, mem_we, rd_fetch;
  logic [ADDR_WIDTH-1:0] wr_next_addr, rd_next_addr, rd_gen_addr;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [2:0]            rd_gen_size;
  logic [1:0]            rd_gen_burst;
  resp_e                 wr_beat_resp, rd_beat_resp;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_inputs;

  assign aw_hs        = awvalid & awready;
  assign w_hs         = wvalid & wready;
  assign ar_hs        = arvalid & arready;
  assign r_hs         = rvalid & rready;
  assign wr_last_beat = (wr_cnt_reg == wr_len_reg);
  assign mem_we       = w_hs & (wr_beat_resp == RESP_OKAY);
  assign rd_fetch     = ar_hs | (r_hs & ~rd_last_reg);
  assign unused_inputs = ^{awlock, awcache, awprot, wid, wsideband, arlock, arcache, arprot};

  axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wr_gen (
    .addr(wr_addr_reg), .size(wr_size_reg), .burst(wr_burst_reg),
    .next_addr(wr_next_addr), .idx(wr_idx), .resp(wr_beat_resp)
  );

  // While idle the read generator looks at the incoming AR so beat 0 is fetched on the handshake.
  assign rd_gen_addr  = (rd_state_reg == RD_IDLE) ? araddr  : rd_addr_reg;
  assign rd_gen_size  = (rd_state_reg == RD_IDLE) ? arsize  : rd_size_reg;
  assign rd_gen_burst = (rd_state_reg == RD_IDLE) ? arburst : rd_burst_reg;

  axi_slv_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rd_gen (
    .addr(rd_gen_addr), .size(rd_gen_size), .burst(rd_gen_burst),
    .next_addr(rd_next_addr), .idx(rd_idx), .resp(rd_beat_resp)
  );

  // One 8-bit array per byte lane; read-before-write ordering gives old data on collisions.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem_lane [MEM_DEPTH];
      logic [7:0] q_reg;
      always_ff @(posedge clock) begin
        if (mem_we && wstrb[gi]) mem_lane[wr_idx] <= wdata[gi*8 +: 8];
        if (rd_fetch)            q_reg <= mem_lane[rd_idx];
      end
      assign rd_word[gi*8 +: 8] = q_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_reg <= WR_IDLE;
      rd_state_reg <= RD_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    case (wr_state_reg)
      WR_IDLE: if (aw_hs) wr_state_next = WR_DATA;
      WR_DATA: if (w_hs && wr_last_beat) wr_state_next = WR_RESP;
      WR_RESP: if (bready) wr_state_next = WR_IDLE;
      default: wr_state_next = WR_IDLE;
    endcase
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (ar_hs) rd_state_next = RD_DATA;
      RD_DATA: if (r_hs && rd_last_reg) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    arready = 1'b0;
    rvalid  = 1'b0;
    if (!reset) begin
      awready = (wr_state_reg == WR_IDLE) && csysack_reg;
      wready  = (wr_state_reg == WR_DATA);
      bvalid  = (wr_state_reg == WR_RESP);
      arready = (rd_state_reg == RD_IDLE) && csysack_reg;
      rvalid  = (rd_state_reg == RD_DATA);
    end
  end

  always_comb begin
    wr_resp_next = resp_max(wr_resp_reg, wr_beat_resp);
    if (wlast != wr_last_beat) wr_resp_next = resp_max(wr_resp_next, RESP_SLVERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr_reg  <= '0;
      wr_len_reg   <= '0;
      wr_cnt_reg   <= '0;
      wr_size_reg  <= '0;
      wr_burst_reg <= '0;
      wr_id_reg    <= '0;
      wr_side_reg  <= '0;
      wr_resp_reg  <= RESP_OKAY;
    end else if (aw_hs) begin
      wr_addr_reg  <= awaddr;
      wr_len_reg   <= awlen;
      wr_cnt_reg   <= '0;
      wr_size_reg  <= awsize;
      wr_burst_reg <= awburst;
      wr_id_reg    <= awid;
      wr_side_reg  <= awsideband;
      wr_resp_reg  <= RESP_OKAY;
    end else if (w_hs) begin
      wr_addr_reg  <= wr_next_addr;
      wr_cnt_reg   <= wr_cnt_reg + 1'b1;
      wr_resp_reg  <= wr_resp_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_reg  <= '0;
      rd_len_reg   <= '0;
      rd_cnt_reg   <= '0;
      rd_size_reg  <= '0;
      rd_burst_reg <= '0;
      rd_id_reg    <= '0;
      rd_side_reg  <= '0;
      rd_resp_reg  <= RESP_OKAY;
      rd_last_reg  <= 1'b0;
      rd_strb_reg  <= '0;
    end else if (ar_hs) begin
      rd_addr_reg  <= rd_next_addr;
      rd_len_reg   <= arlen;
      rd_cnt_reg   <= '0;
      rd_size_reg  <= arsize;
      rd_burst_reg <= arburst;
      rd_id_reg    <= arid;
      rd_side_reg  <= arsideband;
      rd_resp_reg  <= rd_beat_resp;
      rd_last_reg  <= (arlen == '0);
      rd_strb_reg  <= '1;
    end else if (r_hs && !rd_last_reg) begin
      rd_addr_reg  <= rd_next_addr;
      rd_cnt_reg   <= rd_cnt_reg + 1'b1;
      rd_resp_reg  <= rd_beat_resp;
      rd_last_reg  <= ((rd_cnt_reg + 1'b1) == rd_len_reg);
    end
  end

  // Power-down is only granted when nothing is in flight or being accepted this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      csysack_reg <= 1'b1;
      cactive_reg <= 1'b0;
    end else begin
      if (csysack_reg && !csysreq && (wr_state_reg == WR_IDLE) && (rd_state_reg == RD_IDLE) &&
          !aw_hs && !ar_hs)
        csysack_reg <= 1'b0;
      else if (!csysack_reg && csysreq)
        csysack_reg <= 1'b1;
      cactive_reg <= (wr_state_reg != WR_IDLE) || (rd_state_reg != RD_IDLE);
    end
  end

  assign bresp     = wr_resp_reg;
  assign bid       = wr_id_reg;
  assign bsideband = wr_side_reg;
  assign rdata     = (rd_resp_reg == RESP_OKAY) ? rd_word : '0;
  assign rstrb     = rd_strb_reg;
  assign rid       = rd_id_reg;
  assign rsideband = rd_side_reg;
  assign rlast     = rd_last_reg;
  assign rresp     = rd_resp_reg;
  assign csysack   = csysack_reg;
  assign cactive   = cactive_reg;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected B/R responses, a monitor pops them.
module tb_axi_sram_slave;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast, csysreq, csysack, cactive;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen, awid, arid, wid, bid, rid;
  logic [3:0]  awsideband, arsideband, wsideband, bsideband, rsideband;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb, rstrb;

  typedef struct {logic [1:0] resp; logic [3:0] id; logic [3:0] side;} b_exp_t;
  typedef struct {logic [63:0] data; logic last; logic [1:0] resp; logic [3:0] id; logic [3:0] side;} r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [63:0] wdat [16];
  logic [63:0] rexp [16];
  logic [63:0] t1d  [4];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awid(awid), .awsideband(awsideband),
    .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wid(wid), .wsideband(wsideband),
    .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bid(bid), .bsideband(bsideband), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arid(arid), .arsideband(arsideband),
    .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rstrb(rstrb), .rid(rid), .rsideband(rsideband),
    .rlast(rlast), .rresp(rresp), .rready(rready),
    .csysreq(csysreq), .csysack(csysack), .cactive(cactive)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: handshake not seen within budget, expected one", name);
  endtask

  // Monitor: every accepted B or R beat is compared against the head of its queue.
  always @(negedge clock) begin
    b_exp_t be;
    r_exp_t re;
    if (!reset && bvalid && bready) begin
      if (bq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected: got bid %h bresp %0d, expected no response", bid, bresp);
      end else begin
        be = bq.pop_front();
        check("b_resp_id_side", {54'd0, bresp, bid, bsideband}, {54'd0, be.resp, be.id, be.side});
        $display("B  id=%h side=%h resp=%0d", bid, bsideband, bresp);
      end
    end
    if (!reset && rvalid && rready) begin
      if (rq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL r_unexpected: got rdata %h, expected no beat", rdata);
      end else begin
        re = rq.pop_front();
        check("r_data", rdata, re.data);
        check("r_last_resp_id_side", {45'd0, rstrb, rlast, rresp, rid, rsideband},
              {45'd0, 8'hFF, re.last, re.resp, re.id, re.side});
        $display("R  id=%h data=%h last=%b resp=%0d", rid, rdata, rlast, rresp);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [3:0] side,
                          input logic [7:0] strb, input logic [15:0] last_mask,
                          input logic [1:0] exp_resp, input bit drop);
    b_exp_t e;
    int t;
    e.resp = exp_resp; e.id = id; e.side = side;
    bq.push_back(e);
    @(posedge clock); #1;
    awvalid = 1; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awid = id; awsideband = side;
    @(negedge clock); t = 0;
    while (!awready && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) timeout("aw_timeout");
    @(posedge clock); #1;
    awvalid = 0;
    if (drop) csysreq = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wdat[i]; wstrb = strb; wlast = last_mask[i]; wid = id; wsideband = side;
      @(negedge clock);
      if (drop) begin
        check("lp_csysack_hold", {63'd0, csysack}, 64'd1);
        if (i > 0) check("lp_cactive_busy", {63'd0, cactive}, 64'd1);
      end
      t = 0;
      while (!wready && t < 100) begin @(negedge clock); t++; end
      if (t >= 100) timeout("w_timeout");
      @(posedge clock); #1;
    end
    wvalid = 0; wlast = 0;
    @(negedge clock);
    check("b_latency", {63'd0, bvalid}, 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input logic [3:0] side,
                         input logic [1:0] exp_resp, input bit stall);
    r_exp_t e;
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = rexp[i]; e.last = (i == int'(len)); e.resp = exp_resp; e.id = id; e.side = side;
      rq.push_back(e);
    end
    @(posedge clock); #1;
    arvalid = 1; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arid = id; arsideband = side;
    @(negedge clock); t = 0;
    while (!arready && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) timeout("ar_timeout");
    @(posedge clock); #1;
    arvalid = 0;
    @(negedge clock);
    check("r_latency", {63'd0, rvalid}, 64'd1);
    if (stall) begin
      // Beats 0 and 1 transfer on the next two edges, then beat 2 is held for five cycles.
      @(posedge clock); @(posedge clock); #1;
      rready = 0;
      repeat (5) begin
        @(negedge clock);
        check("stall_hold", {62'd0, rvalid, rlast}, 64'd2);
        check("stall_rdata", rdata, rexp[2]);
      end
      @(posedge clock); #1;
      rready = 1;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 300) begin @(negedge clock); t++; end
    if (t >= 300) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: %0d B and %0d R outstanding, expected 0", bq.size(), rq.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    t1d[0] = 64'h1111_2222_3333_4444;
    t1d[1] = 64'h5555_6666_7777_8888;
    t1d[2] = 64'h9999_AAAA_BBBB_CCCC;
    t1d[3] = 64'hDDDD_EEEE_FFFF_0000;
    reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1; csysreq = 1;
    awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0; awsideband = 0;
    wdata = 0; wstrb = 0; wid = 0; wsideband = 0; wlast = 0;
    araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0; arsideband = 0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready_valid", {58'd0, awready, wready, bvalid, arready, rvalid, cactive}, 64'd0);
    check("rst_csysack", {63'd0, csysack}, 64'd1);
    check("rst_resp_strb", {52'd0, bresp, rresp, rstrb}, 64'd0);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check("idle_ready", {62'd0, awready, arready}, 64'd3);

    // INCR burst write then read back.
    for (int i = 0; i < 4; i++) wdat[i] = t1d[i];
    do_write(32'h100, 4'd3, 3'd3, INCR, 4'h1, 4'h5, 8'hFF, 16'h0008, OKAY, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) rexp[i] = t1d[i];
    do_read(32'h100, 4'd3, 3'd3, INCR, 4'h2, 4'h6, OKAY, 1'b0);
    wait_idle();

    // Partial strobe over a zeroed word.
    wdat[0] = 64'h0;
    do_write(32'h200, 4'd0, 3'd3, INCR, 4'h3, 4'h1, 8'hFF, 16'h0001, OKAY, 1'b0);
    wait_idle();
    wdat[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    do_write(32'h200, 4'd0, 3'd3, INCR, 4'h3, 4'h2, 8'h0F, 16'h0001, OKAY, 1'b0);
    wait_idle();
    rexp[0] = 64'h0000_0000_CCCC_DDDD;
    do_read(32'h200, 4'd0, 3'd3, INCR, 4'h4, 4'h3, OKAY, 1'b0);
    wait_idle();

    // Back-pressure on R mid-burst.
    for (int i = 0; i < 4; i++) rexp[i] = t1d[i];
    do_read(32'h100, 4'd3, 3'd3, INCR, 4'h5, 4'h4, OKAY, 1'b1);
    wait_idle();

    // Early wlast, WRAP and oversize bursts.
    for (int i = 0; i < 4; i++) wdat[i] = t1d[i];
    do_write(32'h300, 4'd3, 3'd3, INCR, 4'h6, 4'h7, 8'hFF, 16'h0002, SLVERR, 1'b0);
    wait_idle();
    wdat[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    wdat[1] = 64'hDEAD_BEEF_DEAD_BEEF;
    do_write(32'h100, 4'd1, 3'd3, WRAP, 4'h7, 4'h8, 8'hFF, 16'h0002, SLVERR, 1'b0);
    wait_idle();
    do_write(32'h100, 4'd0, 3'd4, INCR, 4'h8, 4'h9, 8'hFF, 16'h0001, SLVERR, 1'b0);
    wait_idle();
    rexp[0] = t1d[0]; rexp[1] = t1d[1];
    do_read(32'h100, 4'd1, 3'd3, INCR, 4'h9, 4'hA, OKAY, 1'b0);
    wait_idle();
    rexp[0] = 64'h0; rexp[1] = 64'h0;
    do_read(32'h100, 4'd1, 3'd3, WRAP, 4'hA, 4'hB, SLVERR, 1'b0);
    wait_idle();

    // One word past the end of the array.
    wdat[0] = 64'h0BAD_F00D_CAFE_0005;
`ifdef AXI_SLV_DECERR_EN
    do_write(32'h2000, 4'd0, 3'd3, INCR, 4'hB, 4'hC, 8'hFF, 16'h0001, DECERR, 1'b0);
    wait_idle();
    rexp[0] = 64'h0;
    do_read(32'h2000, 4'd0, 3'd3, INCR, 4'hC, 4'hD, DECERR, 1'b0);
    wait_idle();
`else
    do_write(32'h2000, 4'd0, 3'd3, INCR, 4'hB, 4'hC, 8'hFF, 16'h0001, OKAY, 1'b0);
    wait_idle();
    rexp[0] = 64'h0BAD_F00D_CAFE_0005;
    do_read(32'h2000, 4'd0, 3'd3, INCR, 4'hC, 4'hD, OKAY, 1'b0);
    wait_idle();
    do_read(32'h0, 4'd0, 3'd3, INCR, 4'hD, 4'hE, OKAY, 1'b0);
    wait_idle();
`endif

    // Low-power request during a write burst.
    for (int i = 0; i < 4; i++) wdat[i] = t1d[i];
    do_write(32'h400, 4'd3, 3'd3, INCR, 4'hE, 4'hF, 8'hFF, 16'h0008, OKAY, 1'b1);
    wait_idle();
    repeat (3) @(negedge clock);
    check("lp_asleep", {60'd0, csysack, awready, arready, cactive}, 64'd0);
    @(posedge clock); #1;
    csysreq = 1;
    @(posedge clock);
    @(negedge clock);
    check("lp_awake", {61'd0, csysack, awready, arready}, 64'd7);
    for (int i = 0; i < 4; i++) rexp[i] = t1d[i];
    do_read(32'h400, 4'd3, 3'd3, INCR, 4'h1, 4'h2, OKAY, 1'b0);
    wait_idle();

    check("drain_queues", 64'(bq.size() + rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
